// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator: controller states,
// default polynomial/seed and the Fibonacci next-value function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lfsrState_e;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Works on a 64-bit container so one function serves every legal WIDTH;
  // bits above the active width are masked off and never feed back.
  function automatic logic [63:0] lfsrNext(input logic [63:0] value,
                                           input logic [63:0] taps,
                                           input int          width);
    logic [63:0] mask;
    logic        feedback;
    mask     = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    feedback = ^(value & taps & mask);
    return ((value << 1) | {63'd0, feedback}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR register with seed load (zero-seed lock-up guard), shift and hold.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_shift,
  input  logic             i_load,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_loadValue;

  assign w_next      = WIDTH'(lfsrNext(64'(r_out), 64'(TAPS), WIDTH));
  // An all-zero seed would lock the register, so fall back to SEED.
  assign w_loadValue = (i_seed == '0) ? SEED : i_seed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out <= SEED;
    end else if (i_load) begin
      r_out <= w_loadValue;
    end else if (i_shift && !i_hold) begin
      r_out <= w_next;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/lfsr_prpg.sv
// BIST pseudo-random pattern generator: run controller and pattern counter
// around an lfsr_core register.
module lfsr_prpg
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = DEFAULT_TAPS,
  parameter logic [WIDTH-1:0] SEED     = DEFAULT_SEED,
  parameter int               PATTERNS = 160
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              bistmode,
  input  logic                              hold,
  input  logic                              seed_load,
  input  logic [WIDTH-1:0]                  seed_in,
  output logic [WIDTH-1:0]                  out,
  output logic                              sdo,
  output logic [$clog2(PATTERNS+1)-1:0]     pattern_cnt,
  output logic                              busy,
  output logic                              done
);

  localparam int CW = $clog2(PATTERNS + 1);

  lfsrState_e    r_state;
  lfsrState_e    w_nextState;
  logic [CW-1:0] r_cnt;
  logic          w_shift;
  logic          w_load;
  logic          w_cntClear;
  logic          w_lastShift;

  assign w_lastShift = (r_cnt == CW'(PATTERNS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort beats hold in RUN; seed_load beats a start in IDLE/DONE.
  always_comb begin
    w_nextState = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_cntClear  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (seed_load) begin
          w_load = 1'b1;
        end else if (bistmode) begin
          w_nextState = RUN;
          w_cntClear  = 1'b1;
        end
      end
      RUN: begin
        if (!bistmode) begin
          w_nextState = IDLE;
        end else if (!hold) begin
          w_shift = 1'b1;
          if (w_lastShift) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (seed_load) begin
          w_load = 1'b1;
        end else if (!bistmode) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_cntClear) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_shift (w_shift),
    .i_load  (w_load),
    .i_hold  (hold),
    .i_seed  (seed_in),
    .o_out   (out)
  );

  assign sdo         = out[WIDTH-1];
  assign pattern_cnt = r_cnt;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_lfsr_prpg.sv
// Self-checking bench: default 16-bit generator against a behavioural model,
// plus a 4-bit instance checked against its known full-period sequence.
module tb_lfsr_prpg;

  logic        clk;
  logic        rstA, bmA, holdA, slA;
  logic [15:0] siA, outA;
  logic        sdoA, busyA, doneA;
  logic [7:0]  cntA;

  logic        rstB, bmB, holdB, slB;
  logic [3:0]  siB, outB;
  logic        sdoB, busyB, doneB;
  logic [3:0]  cntB;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the 16-bit instance: 0 idle, 1 running, 2 done.
  int          mState;
  logic [15:0] mOut;
  int          mCnt;

  lfsr_prpg dutA (
    .clk(clk), .reset(rstA), .bistmode(bmA), .hold(holdA), .seed_load(slA),
    .seed_in(siA), .out(outA), .sdo(sdoA), .pattern_cnt(cntA),
    .busy(busyA), .done(doneA)
  );

  lfsr_prpg #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1), .PATTERNS(15)) dutB (
    .clk(clk), .reset(rstB), .bistmode(bmB), .hold(holdB), .seed_load(slB),
    .seed_in(siB), .out(outB), .sdo(sdoB), .pattern_cnt(cntB),
    .busy(busyB), .done(doneB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Parity of tapped bits by counting, then shift left by doubling.
  function automatic logic [63:0] refShift(input logic [63:0] v, input logic [63:0] taps, input int w);
    int ones;
    logic [63:0] r;
    ones = 0;
    for (int i = 0; i < w; i++) if (v[i] && taps[i]) ones++;
    r = v * 2 + 64'(ones % 2);
    if (w < 64) r = r % (64'd1 << w);
    return r;
  endfunction

  task automatic stepA();
    if (!rstA) begin
      mState = 0; mOut = 16'hACE1; mCnt = 0;
    end else begin
      case (mState)
        0: if (slA) mOut = (siA == 0) ? 16'hACE1 : siA;
           else if (bmA) begin mState = 1; mCnt = 0; end
        1: if (!bmA) mState = 0;
           else if (!holdA) begin
             mOut = 16'(refShift(64'(mOut), 64'hB400, 16));
             mCnt = mCnt + 1;
             if (mCnt == 160) mState = 2;
           end
        2: if (slA) mOut = (siA == 0) ? 16'hACE1 : siA;
           else if (!bmA) mState = 0;
        default: mState = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 0; rstB = 0;
    stepA(); stepA();
    rstA = 1; rstB = 1;
    stepA();
    checks++; if (outA !== 16'hACE1) begin failures++; $display("[TB] FAIL reset_out: got %h want ace1", outA); end
    checks++; if (cntA !== 8'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d want 0", cntA); end
    checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: got busy=%b done=%b want 0 0", busyA, doneA); end
    checks++; if (outB !== 4'h1 || busyB !== 1'b0) begin failures++; $display("[TB] FAIL reset_b: got out=%h busy=%b want 1 0", outB, busyB); end
  endtask

  task automatic test_full_run();
    bmA = 1;
    stepA();
    checks++; if (busyA !== 1'b1 || cntA !== 8'd0 || outA !== 16'hACE1) begin failures++; $display("[TB] FAIL run_enter: got busy=%b cnt=%0d out=%h want 1 0 ace1", busyA, cntA, outA); end
    stepA();
    checks++; if (outA !== 16'h59C3 || cntA !== 8'd1) begin failures++; $display("[TB] FAIL first_shift: got out=%h cnt=%0d want 59c3 1", outA, cntA); end
    for (int i = 0; i < 159; i++) begin
      stepA();
      checks++; if (outA !== mOut || sdoA !== mOut[15]) begin failures++; $display("[TB] FAIL run_seq[%0d]: got out=%h sdo=%b want %h", i, outA, sdoA, mOut); end
    end
    checks++; if (doneA !== 1'b1 || busyA !== 1'b0 || cntA !== 8'd160) begin failures++; $display("[TB] FAIL run_done: got done=%b busy=%b cnt=%0d want 1 0 160", doneA, busyA, cntA); end
    stepA();
    checks++; if (doneA !== 1'b1 || outA !== mOut || cntA !== 8'd160) begin failures++; $display("[TB] FAIL done_hold: got done=%b out=%h cnt=%0d want 1 %h 160", doneA, outA, cntA, mOut); end
    bmA = 0;
    stepA();
    checks++; if (doneA !== 1'b0 || busyA !== 1'b0 || outA !== mOut) begin failures++; $display("[TB] FAIL done_ack: got done=%b busy=%b out=%h want 0 0 %h", doneA, busyA, outA, mOut); end
  endtask

  task automatic test_width4();
    logic [3:0] seq [16];
    seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    bmB = 1;
    @(posedge clk); #1;
    checks++; if (busyB !== 1'b1 || outB !== 4'h1) begin failures++; $display("[TB] FAIL w4_enter: got busy=%b out=%h want 1 1", busyB, outB); end
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      checks++; if (outB !== seq[i] || cntB !== 4'(i)) begin failures++; $display("[TB] FAIL w4_seq[%0d]: got out=%h cnt=%0d want %h %0d", i, outB, cntB, seq[i], i); end
    end
    checks++; if (doneB !== 1'b1 || busyB !== 1'b0 || outB !== 4'h1) begin failures++; $display("[TB] FAIL w4_done: got done=%b busy=%b out=%h want 1 0 1", doneB, busyB, outB); end
    bmB = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold_abort();
    logic [15:0] frozenOut;
    int frozenCnt;
    bmA = 1;
    stepA();
    for (int i = 0; i < 20; i++) stepA();
    frozenOut = mOut; frozenCnt = mCnt;
    checks++; if (cntA !== 8'd20 || outA !== mOut) begin failures++; $display("[TB] FAIL pre_hold: got cnt=%0d out=%h want 20 %h", cntA, outA, mOut); end
    holdA = 1;
    for (int i = 0; i < 5; i++) begin
      stepA();
      checks++; if (outA !== frozenOut || cntA !== 8'(frozenCnt) || busyA !== 1'b1) begin failures++; $display("[TB] FAIL hold[%0d]: got out=%h cnt=%0d busy=%b want %h %0d 1", i, outA, cntA, busyA, frozenOut, frozenCnt); end
    end
    bmA = 0;
    stepA();
    checks++; if (busyA !== 1'b0 || outA !== frozenOut || cntA !== 8'(frozenCnt)) begin failures++; $display("[TB] FAIL abort: got busy=%b out=%h cnt=%0d want 0 %h %0d", busyA, outA, cntA, frozenOut, frozenCnt); end
    holdA = 0; bmA = 1;
    stepA();
    checks++; if (busyA !== 1'b1 || cntA !== 8'd0 || outA !== frozenOut) begin failures++; $display("[TB] FAIL restart: got busy=%b cnt=%0d out=%h want 1 0 %h", busyA, cntA, outA, frozenOut); end
    bmA = 0;
    stepA();
  endtask

  task automatic test_seed_load();
    slA = 1; siA = 16'h0000;
    stepA();
    checks++; if (outA !== 16'hACE1) begin failures++; $display("[TB] FAIL seed_zero: got %h want ace1", outA); end
    siA = 16'h1234;
    stepA();
    checks++; if (outA !== 16'h1234 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL seed_load: got out=%h busy=%b want 1234 0", outA, busyA); end
    slA = 0; bmA = 1;
    stepA();
    slA = 1; siA = 16'hFFFF;
    stepA();
    checks++; if (outA !== mOut || outA !== 16'(refShift(64'h1234, 64'hB400, 16))) begin failures++; $display("[TB] FAIL seed_in_run: got %h want %h", outA, mOut); end
    slA = 0; bmA = 0;
    stepA();
    slA = 1; bmA = 1; siA = 16'h00FF;
    stepA();
    checks++; if (busyA !== 1'b0 || outA !== 16'h00FF) begin failures++; $display("[TB] FAIL seed_priority: got busy=%b out=%h want 0 00ff", busyA, outA); end
    slA = 0; bmA = 0;
    stepA();
  endtask

  task automatic test_mid_reset();
    bmA = 1;
    stepA();
    for (int i = 0; i < 50; i++) stepA();
    checks++; if (cntA !== 8'd50 || outA !== mOut) begin failures++; $display("[TB] FAIL pre_reset: got cnt=%0d out=%h want 50 %h", cntA, outA, mOut); end
    rstA = 0;
    stepA();
    checks++; if (busyA !== 1'b0 || outA !== 16'hACE1 || cntA !== 8'd0) begin failures++; $display("[TB] FAIL mid_reset: got busy=%b out=%h cnt=%0d want 0 ace1 0", busyA, outA, cntA); end
    rstA = 1; bmA = 0;
    stepA();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      rstA  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) == 0) bmA = ~bmA;
      holdA = ($urandom_range(0, 4) == 0);
      slA   = ($urandom_range(0, 39) == 0);
      siA   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      stepA();
      checks++;
      if (outA !== mOut || sdoA !== mOut[15] || cntA !== 8'(mCnt) ||
          busyA !== (mState == 1) || doneA !== (mState == 2) || outA === 16'h0000) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got out=%h cnt=%0d busy=%b done=%b want %h %0d %0d", i, outA, cntA, busyA, doneA, mOut, mCnt, mState);
      end
    end
  endtask

  initial begin
    rstA = 0; bmA = 0; holdA = 0; slA = 0; siA = '0;
    rstB = 0; bmB = 0; holdB = 0; slB = 0; siB = '0;
    mState = 0; mOut = 16'hACE1; mCnt = 0;
    #2;
    test_reset();
    test_full_run();
    test_width4();
    test_hold_abort();
    test_seed_load();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
